// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_pkg
//  Brief    : Shared constants and types for the 5-stage pipeline
//             sequencing controller (register width, x0, FSM states, NOP).
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // Default register-address width for RV32 (x0..x31)
    localparam int c_REG_W = 5;

    // Hard-wired zero register; a load targeting it never creates a hazard
    localparam logic [c_REG_W-1:0] c_REG_X0 = '0;

    // ADDI x0,x0,0 - loaded into IF/ID by the datapath when if_id_flush is set
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    // Sequencer run state
    typedef enum logic [0:0] {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Up-counter that sticks at its all-ones value instead of
//             wrapping. Used for the retire, stall and flush statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // Count up on inc, holding at the maximum value once reached
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Sequencing controller for a 5-stage RISC-V pipeline. Stalls
//             on load-use hazards, squashes younger instructions on a taken
//             branch/jump in MEM, tracks per-stage valid bits and keeps
//             saturating retire/stall/flush counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = c_REG_W
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_jump,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pc_redirect,
    output logic [3:0]       pipe_valid,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_active;

    logic   r_v_if_id;
    logic   r_v_id_ex;
    logic   r_v_ex_mem;
    logic   r_v_mem_wb;

    logic   w_taken;
    logic   w_load_use;

    // Run-state register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; the HOLD->RUN transition cycle already advances the pipe,
    // so the first instruction enters IF/ID on the first enabled edge
    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        case (r_state)
            HOLD: begin
                if (enable) begin
                    w_state_nxt = RUN;
                    w_active    = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_active    = 1'b1;
                end
            end
            default: w_state_nxt = HOLD;
        endcase
    end

    // Hazard detection, qualified by the valid bits of the stages involved
    assign w_taken    = r_v_ex_mem & ((mem_branch & mem_zero) | mem_jump);
    assign w_load_use = r_v_id_ex & r_v_if_id & ex_mem_read
                      & (ex_rd != REG_W'(c_REG_X0))
                      & ((id_use_rs1 & (id_rs1 == ex_rd))
                       | (id_use_rs2 & (id_rs2 == ex_rd)));

    // Pipeline control; a taken redirect wins since it squashes the stalled op
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_redirect  = 1'b0;
        if (w_active) begin
            if (w_taken) begin
                pc_redirect  = 1'b1;
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (w_load_use) begin
                id_ex_flush  = 1'b1;
            end else begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
            end
        end
    end

    // Valid bits follow the instructions down the pipe; the branch in MEM
    // itself always proceeds to WB
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_v_if_id  <= 1'b0;
            r_v_id_ex  <= 1'b0;
            r_v_ex_mem <= 1'b0;
            r_v_mem_wb <= 1'b0;
        end else if (w_active) begin
            r_v_if_id  <= w_taken ? 1'b0 : (w_load_use ? r_v_if_id : 1'b1);
            r_v_id_ex  <= (w_taken | w_load_use) ? 1'b0 : r_v_if_id;
            r_v_ex_mem <= w_taken ? 1'b0 : r_v_id_ex;
            r_v_mem_wb <= r_v_ex_mem;
        end
    end

    assign pipe_valid = {r_v_if_id, r_v_id_ex, r_v_ex_mem, r_v_mem_wb};

    sat_counter #(.CNT_W(CNT_W)) u_instret (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (w_active & r_v_mem_wb),
        .count  (instret)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (w_active & w_load_use & ~w_taken),
        .count  (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (w_active & w_taken),
        .count  (flush_cnt)
    );

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards in ID and stalls PC and IF/ID while inserting a bubble into ID/EX.
- Squashes the three younger instructions when a branch or jump resolves taken in MEM.
- Tracks a valid bit per pipeline register and keeps saturating retire, stall and flush counters for bring-up and performance checks.

Parameters:
- CNT_W, 32, width of the instret, stall and flush counters.
- REG_W, 5, register-address width.

Ports:
- clk  in  1  main clock
- arst_n  in  1  asynchronous active-low reset
- enable  in  1  global run enable; low freezes the pipeline
- id_rs1  in  REG_W  rs1 field of the instruction in IF/ID
- id_rs2  in  REG_W  rs2 field of the instruction in IF/ID
- id_use_rs1  in  1  the ID instruction reads rs1
- id_use_rs2  in  1  the ID instruction reads rs2
- ex_rd  in  REG_W  rd held in ID/EX
- ex_mem_read  in  1  the ID/EX instruction is a load
- mem_branch  in  1  branch control bit held in EX/MEM
- mem_zero  in  1  zero flag held in EX/MEM
- mem_jump  in  1  jump control bit held in EX/MEM
- pc_en  out  1  PC load enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  clear ID/EX control bits (bubble)
- ex_mem_flush  out  1  clear EX/MEM control bits
- pc_redirect  out  1  select branch/jump target at the PC
- pipe_valid  out  4  {v_if_id, v_id_ex, v_ex_mem, v_mem_wb}
- instret  out  CNT_W  retired-instruction count
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  redirect events

Behaviour:
Reset (arst_n low, asynchronous):
- All valid bits are 0, all counters are 0, FSM goes to HOLD.
- Control outputs follow the combinational equations below, which with enable low give 0 on everything.

FSM:
- HOLD to RUN on enable=1.
- RUN to HOLD on enable=0.
- In HOLD: all outputs except the counters and pipe_valid are 0, and there is no state change.

Combinational decode in RUN (same-cycle, zero latency):
- taken = v_ex_mem & ((mem_branch & mem_zero) | mem_jump).
- load_use = v_id_ex & v_if_id & ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- If taken:
  - pc_redirect=1, pc_en=1, if_id_en=1.
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - taken overrides load_use: the stalled instruction is squashed anyway.
- Else if load_use:
  - pc_en=0, if_id_en=0, id_ex_flush=1.
  - All other flushes 0.
- Else: pc_en=1, if_id_en=1, all flushes 0.

Valid tracking (updated only in RUN):
- v_if_id <= taken ? 0 : (load_use ? v_if_id : 1).
- v_id_ex <= (taken | load_use) ? 0 : v_if_id.
- v_ex_mem <= taken ? 0 : v_id_ex.
- v_mem_wb <= v_ex_mem. The branch itself is never squashed.

Counters (updated only in RUN; each saturates at 2^CNT_W-1, with no wrap):
- instret increments when v_mem_wb=1.
- stall_cnt increments on a cycle with load_use & ~taken.
- flush_cnt increments on a cycle with taken.

Boundary cases:
- After reset the first instruction retires on the 5th RUN cycle, so instret reaches 1 after 5 enabled cycles.
- ex_rd=0 never stalls.
- A load-use pair stalls exactly 1 cycle. On the next cycle v_id_ex=0, so load_use drops and the pipe advances.
- enable dropping mid-stall freezes all state; the same stall re-evaluates when enable returns.
- Back-to-back taken branches are impossible: the younger ones are invalid after a flush.
- Reset mid-operation discards all valids and counters immediately.

Decomposition:
- Shared package holds:
  - REG_W.
  - RISC-V x0 constant.
  - FSM state encoding (HOLD=1'b0, RUN=1'b1).
  - NOP encoding 32'h0000_0013, used by the datapath on if_id_flush.
- One natural sub-module: sat_counter (parameter CNT_W; inputs clk, arst_n, inc; output count).
  - Instantiated three times.
- Hazard and valid logic stay in the top module.

Test Plan:
1. Reset, then enable=1 with no hazards for 8 cycles -> pipe_valid reaches 4'b1111 at cycle 4; instret=4 after cycle 8; stall_cnt=0, flush_cnt=0.
2. ld x5 followed by add x6,x5,x1 (ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1) -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; then normal operation; stall_cnt=1.
3. Same as scenario 2 but ex_rd=0 and id_rs1=0 -> no stall; pc_en stays 1.
4. v_ex_mem=1, mem_branch=1, mem_zero=1 -> pc_redirect=1 and all three flushes=1 in that cycle; next cycle pipe_valid=4'b0001; flush_cnt=1.
5. Taken branch and load_use in the same cycle -> pc_en=1, flushes asserted, stall_cnt unchanged.
6. enable=0 during a stall, then arst_n pulsed low mid-run -> outputs frozen while enable is low; after reset all counters and pipe_valid are 0 with no clock edge required.
